// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one dmem req/ack transaction per M-stage access, with
// store lane formatting, load extension, misalignment rejection and an ack timeout.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  addr_lo;
  logic [2:0]  f3_q;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        aligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  assign access = MemReadM | MemWriteM;

  // Size decode: any code that is not B/BU/H/HU behaves as a word access.
  always_comb begin
    is_byte = (Funct3M == 3'b000) || (Funct3M == 3'b100);
    is_half = (Funct3M == 3'b001) || (Funct3M == 3'b101);
    if (is_byte)      aligned = 1'b1;
    else if (is_half) aligned = ~ALUResultM[0];
    else              aligned = (ALUResultM[1:0] == 2'b00);
  end

  always_comb begin
    st_wdata = WriteDataM;
    st_be    = 4'b1111;
    if (is_byte) begin
      st_wdata = {4{WriteDataM[7:0]}};
      st_be    = 4'b0001 << ALUResultM[1:0];
    end else if (is_half) begin
      st_wdata = {2{WriteDataM[15:0]}};
      st_be    = 4'b0011 << ALUResultM[1:0];
    end
  end

  // Load extraction works from the captured offset/size, never the live inputs.
  always_comb begin
    shifted = dmem_rdata >> {addr_lo, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'b0, shifted[7:0]};
      3'b101:  ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    StallM = access & aligned;
      BUSY:    StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
  end

  assign MisalignM = ~reset & (state == IDLE) & access & ~aligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      addr_lo    <= 2'b00;
      f3_q       <= 3'b000;
      ReadDataM  <= 32'd0;
      BusErrM    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'b0000;
    end else begin
      BusErrM <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (access && aligned) begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_wdata <= st_wdata;
            dmem_be    <= MemWriteM ? st_be : 4'b0000;
            addr_lo    <= ALUResultM[1:0];
            f3_q       <= Funct3M;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            if (!dmem_we) ReadDataM <= ld_data;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (cnt == LAST_CNT) begin
            dmem_req  <= 1'b0;
            ReadDataM <= 32'd0;
            BusErrM   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          cnt   <= 8'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
